// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the seven-segment display arbiter.
//   DIG_W   : width of the hex digit word (4 digits x 4 bits)
//   DP_W    : width of the decimal-point mask (one bit per digit)
//   MAX_REQ : largest supported requester count
//   OWN_W   : width of an owner index
//   state_t : arbiter FSM states
//   onehot  : index -> one-hot vector helper
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int DIG_W   = 16;
    localparam int DP_W    = 4;
    localparam int MAX_REQ = 8;
    localparam int OWN_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/seg7_rr_pick.sv
// -----------------------------------------------------------------------------
// seg7_rr_pick
// Combinational round-robin picker. Searches i_req starting at i_start and
// wrapping modulo N_REQ; the first set bit in that order wins.
//   i_req    : request vector
//   i_start  : index where the search begins (must be < N_REQ)
//   o_found  : at least one request is set
//   o_winner : index of the winning request (i_start when none found)
// -----------------------------------------------------------------------------
module seg7_rr_pick
    import seg7_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [OWN_W-1:0] i_start,
    output logic             o_found,
    output logic [OWN_W-1:0] o_winner
);

    // Each requester's distance from the start in search order; the set
    // request with the smallest distance wins. Distance N_REQ means "none".
    always_comb begin
        int best_d;
        int d;
        best_d   = N_REQ;
        d        = 0;
        o_winner = i_start;
        for (int k = 0; k < N_REQ; k++) begin
            d = (k + N_REQ - int'(i_start)) % N_REQ;
            if (i_req[k] && (d < best_d)) begin
                best_d   = d;
                o_winner = OWN_W'(k);
            end
        end
        o_found = (best_d < N_REQ);
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg7_display_arbiter
// Round-robin arbiter sharing one 4-digit seven-segment display among N_REQ
// requesters. Each grant is held for at least DWELL cycles while competitors
// wait; an owner dropping its request releases the display immediately.
//   iCLK, iRST_N : clock, asynchronous active-low reset
//   iREQ         : per-requester level request
//   iDATA        : requester k hex word at [16k+15:16k]
//   iDP          : requester k decimal-point mask at [4k+3:4k]
//   oGNT         : one-hot grant, zero when idle
//   oOWNER       : current owner, holds last owner when idle
//   oDIG, oDP    : registered digit word / decimal-point mask
//   oBLANK       : high when nobody owns the display
// -----------------------------------------------------------------------------
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [N_REQ-1:0]       iREQ,
    input  logic [DIG_W*N_REQ-1:0] iDATA,
    input  logic [DP_W*N_REQ-1:0]  iDP,
    output logic [N_REQ-1:0]       oGNT,
    output logic [OWN_W-1:0]       oOWNER,
    output logic [DIG_W-1:0]       oDIG,
    output logic [DP_W-1:0]        oDP,
    output logic                   oBLANK
);

    localparam int CNT_W = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    state_t           r_state;
    logic [OWN_W-1:0] r_owner;
    logic [OWN_W-1:0] r_ptr;     // last owner; search starts one past it
    logic [CNT_W-1:0] r_cnt;
    logic [DIG_W-1:0] r_dig;
    logic [DP_W-1:0]  r_dp;

    state_t           w_next_state;
    logic [OWN_W-1:0] w_next_owner;
    logic [OWN_W-1:0] w_next_ptr;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_load;
    logic [OWN_W-1:0] w_start;
    logic             w_found;
    logic [OWN_W-1:0] w_winner;
    logic             w_own_req;
    logic [DIG_W-1:0] w_sel_dig;
    logic [DP_W-1:0]  w_sel_dp;
    logic [N_REQ-1:0] w_gnt;

    // In SHOW r_ptr equals r_owner, so one search start serves both states.
    // Starting one past the owner puts the owner last in the search order.
    assign w_start = (r_ptr == OWN_W'(N_REQ - 1)) ? '0 : r_ptr + 1'b1;

    seg7_rr_pick #(
        .N_REQ   (N_REQ)
    ) u_pick (
        .i_req   (iREQ),
        .i_start (w_start),
        .o_found (w_found),
        .o_winner(w_winner)
    );

    always_comb begin
        w_own_req = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_owner == OWN_W'(k)) w_own_req = iREQ[k];
        end
    end

    // Next-state / next-owner logic.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_cnt   = r_cnt;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = SHOW;
                    w_next_owner = w_winner;
                    w_next_cnt   = '0;
                    w_load       = 1'b1;
                end
            end
            SHOW: begin
                w_load = 1'b1;
                if (!w_own_req) begin
                    // Release bypasses the dwell rule entirely.
                    if (w_found) begin
                        w_next_owner = w_winner;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_state = IDLE;
                        w_load       = 1'b0;
                    end
                end else if (r_cnt == CNT_MAX) begin
                    // Owner is searched last, so winner==owner means no one
                    // else is waiting: stay saturated.
                    if (w_winner != r_owner) begin
                        w_next_owner = w_winner;
                        w_next_cnt   = '0;
                    end
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        w_next_ptr = (w_next_state == SHOW) ? w_next_owner : r_ptr;
    end

    // Data of the owner selected at this edge (new owner on a switch).
    always_comb begin
        w_sel_dig = '0;
        w_sel_dp  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_next_owner == OWN_W'(k)) begin
                w_sel_dig = iDATA[k*DIG_W +: DIG_W];
                w_sel_dp  = iDP[k*DP_W +: DP_W];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= OWN_W'(N_REQ - 1);
            r_cnt   <= '0;
            r_dig   <= '0;
            r_dp    <= '0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            r_ptr   <= w_next_ptr;
            r_cnt   <= w_next_cnt;
            if (w_load) begin
                r_dig <= w_sel_dig;
                r_dp  <= w_sel_dp;
            end
        end
    end

    // Grant and blank decode purely from registered state.
    always_comb begin
        w_gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_gnt[k] = (r_state == SHOW) && (|(onehot(r_owner) & onehot(OWN_W'(k))));
        end
    end

    assign oGNT   = w_gnt;
    assign oOWNER = r_owner;
    assign oDIG   = r_dig;
    assign oDP    = r_dp;
    assign oBLANK = (r_state == IDLE);

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_arbiter
// Self-checking bench for seg7_display_arbiter with N_REQ=4, DWELL=4.
// A cycle model predicts each edge's outputs into exp_q; the DUT output after
// the edge is popped and compared. Directed checks pin the documented cases.
// -----------------------------------------------------------------------------
module tb_seg7_display_arbiter;

    localparam int N_REQ = 4;
    localparam int DWELL = 4;
    localparam int W     = 28;   // {gnt[4], owner[3], dig[16], dp[4], blank}

    logic                iCLK;
    logic                iRST_N;
    logic [N_REQ-1:0]    iREQ;
    logic [16*N_REQ-1:0] iDATA;
    logic [4*N_REQ-1:0]  iDP;
    logic [N_REQ-1:0]    oGNT;
    logic [2:0]          oOWNER;
    logic [15:0]         oDIG;
    logic [3:0]          oDP;
    logic                oBLANK;

    logic [15:0] slot_dig [N_REQ];
    logic [3:0]  slot_dp  [N_REQ];

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_pass;

    // Reference model state
    bit          m_show;
    int          m_owner;
    int          m_ptr;
    int          m_age;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;

    seg7_display_arbiter #(
        .N_REQ (N_REQ),
        .DWELL (DWELL)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iREQ   (iREQ),
        .iDATA  (iDATA),
        .iDP    (iDP),
        .oGNT   (oGNT),
        .oOWNER (oOWNER),
        .oDIG   (oDIG),
        .oDP    (oDP),
        .oBLANK (oBLANK)
    );

    // ---------------- clock ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            iDATA[k*16 +: 16] = slot_dig[k];
            iDP[k*4 +: 4]     = slot_dp[k];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // ---------------- model ----------------
    function automatic int pick(input int start);
        for (int i = 0; i < N_REQ; i++) begin
            if (iREQ[(start + i) % N_REQ]) return (start + i) % N_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_show  = 0;
        m_owner = 0;
        m_ptr   = N_REQ - 1;
        m_age   = 0;
        m_dig   = 16'h0000;
        m_dp    = 4'h0;
    endtask

    task automatic model_grant(input int w);
        m_show  = 1;
        m_owner = w;
        m_ptr   = w;
        m_age   = 0;
    endtask

    task automatic model_step();
        int w;
        if (!m_show) begin
            w = pick((m_ptr + 1) % N_REQ);
            if (w >= 0) model_grant(w);
        end else if (!iREQ[m_owner]) begin
            w = pick((m_owner + 1) % N_REQ);
            if (w >= 0) model_grant(w);
            else m_show = 0;
        end else if (m_age >= DWELL - 1) begin
            w = pick((m_owner + 1) % N_REQ);
            if (w != m_owner) model_grant(w);
        end else begin
            m_age++;
        end
        if (m_show) begin
            m_dig = slot_dig[m_owner];
            m_dp  = slot_dp[m_owner];
        end
    endtask

    function automatic logic [W-1:0] model_word();
        logic [3:0] g;
        g = m_show ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 3'(m_owner), m_dig, m_dp, ~m_show};
    endfunction

    // ---------------- driver ----------------
    // Inputs are changed 1 time unit after a rising edge; outputs are sampled
    // at the same point, after the edge has settled.
    task automatic cycle(input string tag);
        logic [W-1:0] got;
        model_step();
        exp_q.push_back(model_word());
        @(posedge iCLK);
        #1;
        got = {oGNT, oOWNER, oDIG, oDP, oBLANK};
        check(tag, 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        iRST_N   = 1'b0;
        iREQ     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            slot_dig[k] = 16'h0000;
            slot_dp[k]  = 4'h0;
        end
        model_reset();
        repeat (2) @(posedge iCLK);
        #1;
        check("rst_gnt",   32'(oGNT),   32'h0);
        check("rst_owner", 32'(oOWNER), 32'h0);
        check("rst_dig",   32'(oDIG),   32'h0);
        check("rst_dp",    32'(oDP),    32'h0);
        check("rst_blank", 32'(oBLANK), 32'h1);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;

        // Single requester, held indefinitely
        slot_dig[2] = 16'hBEEF;
        slot_dp[2]  = 4'h5;
        iREQ        = 4'b0100;
        cycle("single");
        check("single_gnt",   32'(oGNT),   32'h4);
        check("single_owner", 32'(oOWNER), 32'h2);
        check("single_dig",   32'(oDIG),   32'hBEEF);
        check("single_blank", 32'(oBLANK), 32'h0);
        cycles("single_hold", 10);
        check("single_hold_gnt", 32'(oGNT), 32'h4);

        // Release with nobody pending -> idle, data held
        iREQ = 4'b0000;
        cycle("release_idle");
        check("idle_blank", 32'(oBLANK), 32'h1);
        check("idle_gnt",   32'(oGNT),   32'h0);
        check("idle_dig",   32'(oDIG),   32'hBEEF);

        // Asynchronous reset while showing
        iREQ = 4'b0100;
        cycles("regrant", 2);
        #3;
        iRST_N = 1'b0;
        #1;
        check("arst_blank", 32'(oBLANK), 32'h1);
        check("arst_gnt",   32'(oGNT),   32'h0);
        check("arst_dig",   32'(oDIG),   32'h0);
        check("arst_dp",    32'(oDP),    32'h0);
        model_reset();
        iREQ = 4'b0000;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;

        // Rotation 0,1,3,0 with 4 cycles per grant
        slot_dig[0] = 16'h1111; slot_dp[0] = 4'h1;
        slot_dig[1] = 16'h2222; slot_dp[1] = 4'h2;
        slot_dig[2] = 16'h3333; slot_dp[2] = 4'h4;
        slot_dig[3] = 16'h4444; slot_dp[3] = 4'h8;
        iREQ = 4'b1011;
        for (int c = 1; c <= 13; c++) begin
            cycle("rotate");
            if (c == 1)  check("rot_c1",  32'(oOWNER), 32'd0);
            if (c == 4)  check("rot_c4",  32'(oOWNER), 32'd0);
            if (c == 5)  check("rot_c5",  32'(oOWNER), 32'd1);
            if (c == 8)  check("rot_c8",  32'(oOWNER), 32'd1);
            if (c == 9)  check("rot_c9",  32'(oOWNER), 32'd3);
            if (c == 12) check("rot_c12", 32'(oOWNER), 32'd3);
            if (c == 13) check("rot_c13", 32'(oGNT),   32'h1);
        end

        // Early release: owner 1 drops at dwell cycle 1 with 3 pending
        iREQ = 4'b1010;
        cycle("to_owner1");
        check("early_owner1", 32'(oOWNER), 32'd1);
        cycle("dwell1");
        iREQ = 4'b1000;
        cycle("early_release");
        check("early_gnt", 32'(oGNT), 32'h8);
        check("early_dig", 32'(oDIG), 32'h4444);
        iREQ = 4'b1010;
        cycles("early_cnt_cleared", 3);
        check("early_hold3", 32'(oOWNER), 32'd3);
        cycle("early_rotate");
        check("early_rot1", 32'(oOWNER), 32'd1);
        iREQ = 4'b0000;
        cycle("early_idle");
        check("early_blank", 32'(oBLANK), 32'h1);
        check("early_dig_hold", 32'(oDIG), 32'h2222);

        // Live data and late request on a saturated counter
        slot_dig[0] = 16'h1234;
        iREQ = 4'b0001;
        cycle("live_grant");
        check("live_dig0", 32'(oDIG), 32'h1234);
        slot_dig[0] = 16'h5678;
        cycle("live_update");
        check("live_dig1", 32'(oDIG), 32'h5678);
        cycles("live_alone", 8);
        iREQ = 4'b0101;
        cycle("late_req");
        check("late_gnt", 32'(oGNT), 32'h4);
        check("late_dig", 32'(oDIG), 32'h3333);

        // Wrap-around: owner 3 with all requesting -> 0 next
        iREQ = 4'b1111;
        cycles("wrap_a", 4);
        check("wrap_owner3", 32'(oOWNER), 32'd3);
        cycles("wrap_b", 4);
        check("wrap_owner0", 32'(oOWNER), 32'd0);

        // Random traffic under the scoreboard
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) iREQ = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) begin
                slot_dig[$urandom_range(0, N_REQ - 1)] = 16'($urandom_range(0, 65535));
                slot_dp[$urandom_range(0, N_REQ - 1)]  = 4'($urandom_range(0, 15));
            end
            cycle("random");
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
